// File: rtl/ifns_pkg.sv
// Shared IFNS lane types and widths.
package ifns_pkg;
   localparam int IFNS_DATA_W = 10;
   localparam int IFNS_CODE_W = 14;

   typedef enum logic {
      IDLE,
      BURST
   } sched_state_t;
endpackage

// File: rtl/ifns_rr_pick.sv
// Round-robin priority pick: first valid index after rr_ptr, wrapping.
module ifns_rr_pick
   import ifns_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [SRC_W-1:0]   rr_ptr,
   output logic               any,
   output logic [SRC_W-1:0]   pick
);

   logic [SRC_W-1:0] idx;

   // Scan farthest-first so the nearest valid index wins.
   always_comb begin
      any  = |req_valid;
      pick = '0;
      idx  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_valid[idx])
            pick = idx;
      end
   end

endmodule

// File: rtl/ifns_lane_scheduler.sv
// Round-robin burst scheduler feeding one shared IFNS encoder lane.
// Optional per-requester stats counters: define IFNS_SCHED_STATS_EN.
module ifns_lane_scheduler
   import ifns_pkg::*;
#(
   parameter int                     NUM_REQ     = 4,
   parameter int                     MAX_BURST   = 8,
   parameter logic [IFNS_DATA_W-1:0] IDLE_WORD   = 10'h000,
   parameter int                     ENC_LATENCY = 1,
   localparam int                    SRC_W       = $clog2(NUM_REQ)
) (
   input  logic                           clock,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_last,
   input  logic [NUM_REQ*IFNS_DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [IFNS_DATA_W-1:0]         enc_datain,
   output logic                           enc_valid,
   output logic                           out_valid,
   output logic [SRC_W-1:0]               out_src,
`ifdef IFNS_SCHED_STATS_EN
   output logic [NUM_REQ*16-1:0]          stat_words,
   output logic [NUM_REQ*16-1:0]          stat_grants,
`endif
   output logic                           busy
);

   sched_state_t state, state_nxt;

   logic [SRC_W-1:0]       owner, owner_nxt;
   logic [SRC_W-1:0]       rr_ptr, rr_nxt;
   logic [SRC_W-1:0]       pick;
   logic [7:0]             burst_cnt, cnt_nxt;
   logic                   any_valid;
   logic                   grant;
   logic                   xfer;
   logic                   cap_hit;
   logic [IFNS_DATA_W-1:0] owner_data;
   logic [SRC_W-1:0]       enc_src;
   logic                   vld_dly [ENC_LATENCY];
   logic [SRC_W-1:0]       src_dly [ENC_LATENCY];

   ifns_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .any       (any_valid),
      .pick      (pick)
   );

   assign busy       = (state == BURST);
   assign grant      = (state == IDLE) & any_valid;
   assign owner_data = req_data[int'(owner)*IFNS_DATA_W +: IFNS_DATA_W];
   assign cap_hit    = ({1'b0, burst_cnt} + 9'd1) == 9'(MAX_BURST);

   // Exit on last, cap, or owner dropping valid (no transfer then).
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      rr_nxt    = rr_ptr;
      cnt_nxt   = burst_cnt;
      req_ready = '0;
      xfer      = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_valid) begin
               state_nxt = BURST;
               owner_nxt = pick;
               cnt_nxt   = '0;
            end
         end
         BURST: begin
            req_ready[owner] = 1'b1;
            xfer = req_valid[owner];
            if (xfer)
               cnt_nxt = burst_cnt + 8'd1;
            if (!req_valid[owner] || req_last[owner] || cap_hit) begin
               state_nxt = IDLE;
               rr_nxt    = owner;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= SRC_W'(NUM_REQ - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         rr_ptr    <= rr_nxt;
         burst_cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         enc_datain <= IDLE_WORD;
         enc_valid  <= 1'b0;
         enc_src    <= '0;
      end else begin
         enc_datain <= xfer ? owner_data : IDLE_WORD;
         enc_valid  <= xfer;
         enc_src    <= xfer ? owner : '0;
      end
   end

   // Tracks the encoder register stages so tags line up with codeout.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENC_LATENCY; i++) begin
            vld_dly[i] <= 1'b0;
            src_dly[i] <= '0;
         end
      end else begin
         vld_dly[0] <= enc_valid;
         src_dly[0] <= enc_src;
         for (int i = 1; i < ENC_LATENCY; i++) begin
            vld_dly[i] <= vld_dly[i-1];
            src_dly[i] <= src_dly[i-1];
         end
      end
   end

   assign out_valid = vld_dly[ENC_LATENCY-1];
   assign out_src   = src_dly[ENC_LATENCY-1];

`ifdef IFNS_SCHED_STATS_EN
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         stat_words  <= '0;
         stat_grants <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer && owner == SRC_W'(i) &&
                stat_words[16*i +: 16] != 16'hFFFF)
               stat_words[16*i +: 16] <= stat_words[16*i +: 16] + 16'd1;
            if (grant && pick == SRC_W'(i) &&
                stat_grants[16*i +: 16] != 16'hFFFF)
               stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
         end
      end
   end
`endif

endmodule
